// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs one-outstanding SRAM handshake, buffers {pc, inst}.
// Optional macro FETCH_ADEL_EN: misaligned redirect targets halt fetch and emit one out_adel entry.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'hbfc00000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready
`ifdef FETCH_ADEL_EN
  ,
  output logic        out_adel
`endif
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DISCARD
`ifdef FETCH_ADEL_EN
    ,
    HALT
`endif
  } state_t;

  state_t           state, state_n;
  logic [31:0]      pc, pc_n, req_pc, tgt_pc;
  logic [CNT_W-1:0] count, count_n;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n, wr_ptr;
  logic [31:0]      buf_pc   [BUF_DEPTH];
  logic [31:0]      buf_inst [BUF_DEPTH];
  logic             accept, push, pop;
  logic [31:0]      push_pc, push_inst;
`ifdef FETCH_ADEL_EN
  logic             buf_adel [BUF_DEPTH];
  logic             adel_pend, adel_pend_n, push_adel;
`endif

`ifdef FETCH_ADEL_EN
  assign tgt_pc = redirect_pc;
`else
  assign tgt_pc = redirect_pc & ~32'h3;
`endif

  // Next-state, PC and buffer bookkeeping; a redirect overrides the normal transition.
  always_comb begin
    accept    = inst_req & inst_addr_ok;
    pop       = out_valid & out_ready & ~redirect_valid;
    push      = (state == WAIT) & inst_data_ok & ~redirect_valid;
    push_pc   = req_pc;
    push_inst = inst_rdata;
    state_n   = state;
    pc_n      = pc;
`ifdef FETCH_ADEL_EN
    push_adel   = 1'b0;
    adel_pend_n = adel_pend;
`endif
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
`ifdef FETCH_ADEL_EN
        if (adel_pend) begin
          state_n     = HALT;
          push        = ~redirect_valid;
          push_pc     = pc;
          push_inst   = 32'h0;
          push_adel   = 1'b1;
          adel_pend_n = 1'b0;
        end else
`endif
        if (accept) begin
          state_n = WAIT;
          pc_n    = pc + 32'd4;
        end
      end
      WAIT, DISCARD: if (inst_data_ok) state_n = REQ;
      default: ;
    endcase
    if (redirect_valid) begin
      pc_n = tgt_pc;
      case (state)
        REQ:           state_n = accept ? DISCARD : REQ;
        WAIT, DISCARD: state_n = inst_data_ok ? REQ : DISCARD;
        default:       state_n = REQ;
      endcase
`ifdef FETCH_ADEL_EN
      adel_pend_n = |redirect_pc[1:0];
`endif
    end
    count_n  = redirect_valid ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_n = redirect_valid ? wr_ptr : rd_ptr + PTR_W'(pop);
  end

  // State, buffer storage and registered outputs (computed from next-cycle values).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_pc    <= 32'h0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      inst_req  <= 1'b0;
      inst_addr <= RESET_PC;
      out_valid <= 1'b0;
      out_pc    <= 32'h0;
      out_inst  <= 32'h0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_pc[i]   <= 32'h0;
        buf_inst[i] <= 32'h0;
`ifdef FETCH_ADEL_EN
        buf_adel[i] <= 1'b0;
`endif
      end
`ifdef FETCH_ADEL_EN
      adel_pend <= 1'b0;
      out_adel  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      count  <= count_n;
      rd_ptr <= rd_ptr_n;
      if (accept) req_pc <= pc;
      if (push) begin
        buf_pc[wr_ptr]   <= push_pc;
        buf_inst[wr_ptr] <= push_inst;
`ifdef FETCH_ADEL_EN
        buf_adel[wr_ptr] <= push_adel;
`endif
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
`ifdef FETCH_ADEL_EN
      adel_pend <= adel_pend_n;
      inst_req  <= (state_n == REQ) && (count_n < CNT_W'(BUF_DEPTH)) && !adel_pend_n;
`else
      inst_req  <= (state_n == REQ) && (count_n < CNT_W'(BUF_DEPTH));
`endif
      inst_addr <= pc_n;
      out_valid <= (count_n != '0);
      // A push into an emptying buffer becomes the head directly.
      if (push && (wr_ptr == rd_ptr_n)) begin
        out_pc   <= push_pc;
        out_inst <= push_inst;
`ifdef FETCH_ADEL_EN
        out_adel <= push_adel;
`endif
      end else if (count_n != '0) begin
        out_pc   <= buf_pc[rd_ptr_n];
        out_inst <= buf_inst[rd_ptr_n];
`ifdef FETCH_ADEL_EN
        out_adel <= buf_adel[rd_ptr_n];
`endif
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, stall/redirect sequences, randomized run vs stream model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam int          DEPTH    = 2;
  localparam logic        L        = 1'b0;
  localparam logic        H        = 1'b1;
  localparam logic [31:0] Z32      = 32'h0;

  logic        clk, rst_n;
  logic        redirect_valid, inst_req, inst_addr_ok, inst_data_ok, out_valid, out_ready;
  logic [31:0] redirect_pc, inst_addr, inst_rdata, out_pc, out_inst;
`ifdef FETCH_ADEL_EN
  logic        out_adel;
`endif

  fetch_ctrl #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready)
`ifdef FETCH_ADEL_EN
    , .out_adel(out_adel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed, total;

  // Reference model: instruction stream positions and buffer occupancy.
  logic        m_pending, m_squash, m_first, junk_dok;
  int          m_delay, m_count, accepts, pops;
  logic [31:0] m_addr, m_fetch_exp, m_pop_exp;

  typedef struct {
    logic        rdir;
    logic [31:0] rpc;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        ordy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;
  vec_t vecs [15];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5a5a_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(inst_req),  32'(0));
    chk({tag, "_addr"},  inst_addr,      RESET_PC);
    chk({tag, "_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_pc"},    out_pc,         Z32);
    chk({tag, "_inst"},  out_inst,       Z32);
`ifdef FETCH_ADEL_EN
    chk({tag, "_adel"},  32'(out_adel),  32'(0));
`endif
  endtask

  task automatic model_reset();
    m_pending = 1'b0; m_squash = 1'b0; m_first = 1'b1;
    m_delay = 0; m_count = 0;
    m_fetch_exp = RESET_PC; m_pop_exp = RESET_PC;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = Z32; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0; inst_rdata = Z32; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle at the negedge: check current outputs, drive inputs, advance the model.
  task automatic tick(input logic rdir, input logic [31:0] rpc, input logic ordy,
                      input logic aok_rand, input int max_lat);
    logic        aok, due;
    logic [31:0] tgt;
    chk("req_rule",   32'(inst_req),  32'(!m_pending && m_count < DEPTH && !m_first));
    chk("valid_rule", 32'(out_valid), 32'(m_count != 0));
    if (inst_req) chk("fetch_addr", inst_addr, m_fetch_exp);
    if (out_valid) begin
      chk("head_pc",   out_pc,   m_pop_exp);
      chk("head_inst", out_inst, inst_of(m_pop_exp));
`ifdef FETCH_ADEL_EN
      chk("head_adel", 32'(out_adel), 32'(0));
`endif
    end
    due = m_pending && (m_delay == 0);
    aok = inst_req && (!aok_rand || ($urandom_range(0, 2) != 0));
    redirect_valid = rdir;
    redirect_pc    = rpc;
    out_ready      = ordy;
    inst_addr_ok   = aok;
    inst_data_ok   = due || junk_dok;
    inst_rdata     = due ? inst_of(m_addr) : $urandom();
    if (out_valid && ordy && !rdir) begin
      m_pop_exp += 32'd4; m_count--; pops++;
    end
    if (due) begin
      m_pending = 1'b0;
      if (!m_squash && !rdir) m_count++;
    end else if (m_pending) m_delay--;
    if (aok) begin
      m_pending = 1'b1; m_squash = 1'b0; m_addr = inst_addr;
      m_delay = int'($urandom_range(0, max_lat));
      m_fetch_exp += 32'd4; accepts++;
    end
    if (rdir) begin
      tgt = rpc & ~32'h3;
      m_count = 0; m_fetch_exp = tgt; m_pop_exp = tgt;
      if (m_pending) m_squash = 1'b1;
    end
    m_first = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_with_junk();
    do_reset();
    junk_dok = 1'b1;
    repeat (2) tick(L, Z32, H, H, 0);
    junk_dok = 1'b0;
  endtask

  initial begin
    logic        rdir;
    logic [31:0] rpc;
    passed = 0; total = 0; junk_dok = 1'b0; accepts = 0; pops = 0;
    rst_n = 1'b0;
    //            rdir rpc           aok dok rdata         ordy  req addr          ov  pc            inst
    vecs[0]  = '{L, Z32,          L, L, Z32,          H,  L, 32'hbfc00000, L, Z32,          Z32};
    vecs[1]  = '{L, Z32,          H, L, Z32,          H,  H, 32'hbfc00000, L, Z32,          Z32};
    vecs[2]  = '{L, Z32,          L, H, 32'ha0a0a0a0, H,  L, 32'hbfc00004, L, Z32,          Z32};
    vecs[3]  = '{L, Z32,          H, L, Z32,          H,  H, 32'hbfc00004, H, 32'hbfc00000, 32'ha0a0a0a0};
    vecs[4]  = '{L, Z32,          L, H, 32'ha1a1a1a1, H,  L, 32'hbfc00008, L, Z32,          Z32};
    vecs[5]  = '{L, Z32,          H, L, Z32,          H,  H, 32'hbfc00008, H, 32'hbfc00004, 32'ha1a1a1a1};
    vecs[6]  = '{H, 32'h80000100, L, L, Z32,          H,  L, 32'hbfc0000c, L, Z32,          Z32};
    vecs[7]  = '{L, Z32,          L, H, 32'hdead0008, H,  L, 32'h80000100, L, Z32,          Z32};
    vecs[8]  = '{L, Z32,          H, L, Z32,          H,  H, 32'h80000100, L, Z32,          Z32};
    vecs[9]  = '{L, Z32,          L, H, 32'hb0b0b0b0, H,  L, 32'h80000104, L, Z32,          Z32};
    vecs[10] = '{H, 32'hfffffffc, H, L, Z32,          H,  H, 32'h80000104, H, 32'h80000100, 32'hb0b0b0b0};
    vecs[11] = '{L, Z32,          L, H, 32'hdead0104, H,  L, 32'hfffffffc, L, Z32,          Z32};
    vecs[12] = '{L, Z32,          H, L, Z32,          H,  H, 32'hfffffffc, L, Z32,          Z32};
    vecs[13] = '{H, 32'h80000200, L, H, 32'hc0c0c0c0, H,  L, 32'h00000000, L, Z32,          Z32};
    vecs[14] = '{L, Z32,          L, L, Z32,          H,  H, 32'h80000200, L, Z32,          Z32};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("vec%0d_req", i),   32'(inst_req),  32'(vecs[i].e_req));
      chk($sformatf("vec%0d_addr", i),  inst_addr,      vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d_pc", i),   out_pc,   vecs[i].e_pc);
        chk($sformatf("vec%0d_inst", i), out_inst, vecs[i].e_inst);
      end
      redirect_valid = vecs[i].rdir;  redirect_pc  = vecs[i].rpc;
      inst_addr_ok   = vecs[i].aok;   inst_data_ok = vecs[i].dok;
      inst_rdata     = vecs[i].rdata; out_ready    = vecs[i].ordy;
      @(negedge clk);
    end

    // Decode stall: buffer fills to depth, fetch stops, then drains in order and resumes.
    do_reset();
    accepts = 0;
    repeat (12) tick(L, Z32, L, L, 0);
    chk("stall_accepts", 32'(accepts), 32'(2));
    chk("stall_req", 32'(inst_req), 32'(0));
    pops = 0;
    repeat (2) tick(L, Z32, H, L, 0);
    chk("stall_pops", 32'(pops), 32'(2));
    repeat (4) tick(L, Z32, H, L, 0);
    chk("stall_resume", 32'(accepts > 2), 32'(1));

    // Randomized traffic with a mid-run asynchronous reset and late data_ok.
    reset_with_junk();
    for (int c = 0; c < 3000; c++) begin
      rdir = ($urandom_range(0, 11) == 0);
      rpc  = 32'h80000000 + 32'($urandom_range(0, 63)) * 32'd4;
      if ($urandom_range(0, 15) == 0) rpc = 32'hfffffff8;
`ifndef FETCH_ADEL_EN
      rpc[1:0] = 2'($urandom_range(0, 3));
`endif
      if (c == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        reset_with_junk();
      end
      tick(rdir, rpc, $urandom_range(0, 3) != 0, H, 3);
    end

    // Misaligned redirect target.
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h80000102;
    @(negedge clk);
    redirect_valid = 1'b0; redirect_pc = Z32;
`ifdef FETCH_ADEL_EN
    chk("adel_req0", 32'(inst_req), 32'(0));
    @(negedge clk);
    chk("adel_valid", 32'(out_valid), 32'(1));
    chk("adel_pc",    out_pc,         32'h80000102);
    chk("adel_inst",  out_inst,       Z32);
    chk("adel_flag",  32'(out_adel),  32'(1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("adel_hold_valid", 32'(out_valid), 32'(1));
      chk("adel_hold_req",   32'(inst_req),  32'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("adel_drained", 32'(out_valid), 32'(0));
      chk("adel_halt_req", 32'(inst_req), 32'(0));
      @(negedge clk);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80000200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("adel_restart_req",  32'(inst_req), 32'(1));
    chk("adel_restart_addr", inst_addr,     32'h80000200);
`else
    chk("align_req",  32'(inst_req), 32'(1));
    chk("align_addr", inst_addr,     32'h80000100);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer between the PC datapath and the instruction SRAM port.
- Owns the fetch PC and drives a req/addr_ok/data_ok handshake to instruction memory, with at most one access outstanding.
- Absorbs redirects from decode (branch/jump targets) and discards squashed responses.
- Buffers fetched {pc, inst} pairs in a small FIFO so a decode stall (out_ready=0) never loses data.

Parameters:
RESET_PC, 32'hbfc00000, fetch address after reset
BUF_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
redirect_valid  in  1  redirect fetch this cycle (jump/branch taken)
redirect_pc  in  32  redirect target
inst_req  out  1  SRAM request valid
inst_addr  out  32  SRAM request address
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  read data valid this cycle
inst_rdata  in  32  read data
out_valid  out  1  buffer head valid
out_pc  out  32  head PC
out_inst  out  32  head instruction
out_ready  in  1  decode accepts head (decode allowIN)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, pc=RESET_PC, buffer empty.
  - Outputs: inst_req=0, inst_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=0.
- States: IDLE, REQ, WAIT, DISCARD.
- IDLE: first cycle after reset release; always go to REQ.
- REQ:
  - inst_req=1 only if (count + outstanding) < BUF_DEPTH; otherwise inst_req=0 and stay in REQ.
  - inst_addr=pc.
  - On inst_addr_ok: latch req_pc=pc, pc<=pc+4 (mod 2^32), go to WAIT.
- WAIT: on inst_data_ok, push {req_pc, inst_rdata} into the buffer, go to REQ. Data_ok is never expected in REQ or IDLE.
- DISCARD: on inst_data_ok, drop the data, go to REQ.
- Redirect (redirect_valid=1), effective next edge:
  - pc<=redirect_pc; buffer flushed (count=0), so out_valid=0 next cycle; the same-cycle pop is void.
  - In REQ with no addr_ok: request retargeted; inst_addr=redirect_pc next cycle. Addresses not yet accepted may change.
  - In REQ with addr_ok: state<=DISCARD; pc<=redirect_pc (no +4).
  - In WAIT with no data_ok: state<=DISCARD.
  - In WAIT with data_ok: data dropped, state<=REQ.
  - In DISCARD: stay in DISCARD until data_ok. A redirect coinciding with data_ok still goes to REQ with the new pc.
  - In IDLE: pc<=redirect_pc, go to REQ.
- Buffer:
  - Synchronous FIFO, push/pop in the same cycle allowed.
  - out_valid = (count != 0); out_pc/out_inst = head entry, held stable while out_ready=0.
  - Pop when out_valid & out_ready.
  - Push when full is impossible by the credit check above.
- Latency:
  - First inst_req is in cycle 1 after rst_n rises.
  - data_ok in cycle N gives out_valid in N+1.
  - Peak throughput: one instruction per 2 cycles with a 1-cycle SRAM.
- Reset mid-operation: everything returns to reset values immediately. A late data_ok after reset is ignored (state IDLE/REQ).
- Without the optional feature, redirect_pc[1:0] is forced to 2'b00.

Optional Feature:
FETCH_ADEL_EN
- Defined:
  - Adds output out_adel (1 bit, reset 0) carried per buffer entry.
  - A redirect with redirect_pc[1:0]!=0 sets state to a HALT state after any required DISCARD.
  - No SRAM request is issued; one entry {pc=redirect_pc, inst=32'h0, adel=1} is pushed.
  - Fetch then stalls until the next redirect.
- Undefined: no out_adel port, no HALT state; misaligned targets are force-aligned.

Test Plan:
- Reset release, SRAM addr_ok/data_ok 1 cycle each, out_ready=1 -> inst_addr 0xbfc00000, then 0xbfc00004; out_pc/out_inst match in order.
- out_ready=0 held -> exactly 2 entries fetched, then inst_req stays 0. Raising out_ready -> pops 0xbfc00000 and 0xbfc00004 in order, then fetch resumes.
- Redirect to 0x80000100 while in WAIT for 0xbfc00008 -> that data is dropped (never on out_*); next inst_addr is 0x80000100.
- Redirect in the same cycle as data_ok and addr_ok variants -> no stale instruction ever appears on out_valid; buffer empty the cycle after the redirect.
- pc=32'hfffffffc fetched -> next inst_addr=32'h00000000 (wrap).
- With FETCH_ADEL_EN, redirect to 0x80000102 -> one entry with out_adel=1, out_pc=0x80000102, no inst_req until the next redirect. Without the macro -> inst_addr=0x80000100.
